// File: rtl/mycpu_pkg.sv
// Shared encodings for the MEM pipeline stage: access sizes, stage states, datapath widths.
package mycpu_pkg;

    localparam int unsigned DATA_W_32 = 32;
    localparam int unsigned DATA_W_64 = 64;

    localparam logic [1:0] MEM_SIZE_W = 2'b00;
    localparam logic [1:0] MEM_SIZE_B = 2'b01;
    localparam logic [1:0] MEM_SIZE_H = 2'b10;
    localparam logic [1:0] MEM_SIZE_D = 2'b11;

    typedef enum logic [1:0] {
        MS_EMPTY = 2'd0,
        MS_EXEC  = 2'd1,
        MS_WAIT  = 2'd2
    } ms_state_e;

endpackage

// File: rtl/load_align.sv
// Selects the addressed lane of a memory read word and zero/sign-extends it to DATA_W.
module load_align
    import mycpu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    localparam int unsigned OFF_W = (DATA_W == DATA_W_64) ? 3 : 2
) (
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [OFF_W-1:0]  i_offset,
    input  logic [1:0]        i_mem_size,
    input  logic              i_sign_ext,
    output logic [DATA_W-1:0] o_value
);

    logic [OFF_W-1:0]  w_off_mask;
    logic [OFF_W-1:0]  w_lane_off;
    logic [DATA_W-1:0] w_shifted;
    logic [DATA_W-1:0] w_low_mask;
    logic              w_msb;

    // Misaligned offsets are truncated to the access size rather than trapped.
    always_comb begin
        w_off_mask = '0;
        w_low_mask = '1;
        unique case (i_mem_size)
            MEM_SIZE_B: begin
                w_off_mask = '1;
                w_low_mask = DATA_W'(8'hFF);
            end
            MEM_SIZE_H: begin
                w_off_mask = ~OFF_W'(1);
                w_low_mask = DATA_W'(16'hFFFF);
            end
            MEM_SIZE_W: begin
                w_off_mask = ~OFF_W'(3);
                w_low_mask = DATA_W'(32'hFFFF_FFFF);
            end
            default: begin
                w_off_mask = '0;
                w_low_mask = '1;
            end
        endcase
    end

    assign w_lane_off = i_offset & w_off_mask;
    assign w_shifted  = i_rdata >> {w_lane_off, 3'b000};

    always_comb begin
        w_msb = w_shifted[DATA_W-1];
        unique case (i_mem_size)
            MEM_SIZE_B: w_msb = w_shifted[7];
            MEM_SIZE_H: w_msb = w_shifted[15];
            MEM_SIZE_W: w_msb = w_shifted[31];
            default:    w_msb = w_shifted[DATA_W-1];
        endcase
    end

    assign o_value = (w_shifted & w_low_mask) | ((i_sign_ext & w_msb) ? ~w_low_mask : '0);

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: holds one instruction, waits for its load response, aligns it and
// forwards the result to WB and ID; responses orphaned by a flush are counted and dropped.
module mem_stage_pipe
    import mycpu_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DROP_W = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              es_to_ms_valid,
    input  logic [31:0]       es_pc,
    input  logic [DATA_W-1:0] es_result,
    input  logic [4:0]        es_dest,
    input  logic              es_gr_we,
    input  logic              es_load,
    input  logic              es_req_sent,
    input  logic [1:0]        es_mem_size,
    input  logic              es_sign_ext,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata,
    input  logic              flush,
    input  logic              ws_allowin,
    output logic              ms_allowin,
    output logic              ms_to_ws_valid,
    output logic [31:0]       ws_pc,
    output logic [DATA_W-1:0] ws_result,
    output logic [4:0]        ws_dest,
    output logic              ws_gr_we,
    output logic              fwd_valid,
    output logic              fwd_stall,
    output logic [4:0]        fwd_dest,
    output logic [DATA_W-1:0] fwd_result
);

    localparam int unsigned OFF_W  = (DATA_W == DATA_W_64) ? 3 : 2;
    localparam int unsigned SUM_W  = DROP_W + 1;
    localparam logic [SUM_W-1:0] DROP_MAX = SUM_W'({DROP_W{1'b1}});

    ms_state_e         r_state;
    ms_state_e         w_state_nxt;
    logic [DROP_W-1:0] r_drop;
    logic [DROP_W-1:0] w_drop_nxt;
    logic [SUM_W-1:0]  w_drop_sum;

    logic [31:0]       r_pc;
    logic [DATA_W-1:0] r_result;
    logic [4:0]        r_dest;
    logic              r_gr_we;
    logic              r_load;
    logic [1:0]        r_mem_size;
    logic              r_sign_ext;
    logic [DATA_W-1:0] r_ld_data;

    logic              w_ready_go;
    logic              w_accept;
    logic              w_capture;
    logic              w_drop_zero;
    logic              w_inc_wait;
    logic              w_inc_ex;
    logic              w_dec;
    logic [DATA_W-1:0] w_ld_val;

    assign w_drop_zero = (r_drop == '0);
    assign w_ready_go  = (r_state == MS_EXEC);
    assign ms_allowin  = w_drop_zero & ((r_state == MS_EMPTY) | (w_ready_go & ws_allowin));
    assign w_accept    = es_to_ms_valid & ms_allowin & ~flush;
    assign w_capture   = (r_state == MS_WAIT) & data_data_ok & w_drop_zero;

    // Each flushed request still owes a response; those responses must be swallowed.
    assign w_inc_wait = flush & (r_state == MS_WAIT) & ~data_data_ok;
    assign w_inc_ex   = flush & es_to_ms_valid & es_load & es_req_sent;
    assign w_dec      = data_data_ok & ~w_drop_zero;

    always_comb begin
        w_state_nxt = r_state;
        w_drop_sum  = SUM_W'(r_drop) + SUM_W'(w_inc_wait) + SUM_W'(w_inc_ex) - SUM_W'(w_dec);
        w_drop_nxt  = (w_drop_sum > DROP_MAX) ? DROP_W'(DROP_MAX) : DROP_W'(w_drop_sum);

        if (flush) begin
            w_state_nxt = MS_EMPTY;
        end else if (w_accept) begin
            w_state_nxt = (es_load & es_req_sent) ? MS_WAIT : MS_EXEC;
        end else begin
            unique case (r_state)
                MS_EMPTY: w_state_nxt = MS_EMPTY;
                MS_WAIT:  w_state_nxt = w_capture ? MS_EXEC : MS_WAIT;
                MS_EXEC:  w_state_nxt = ws_allowin ? MS_EMPTY : MS_EXEC;
                default:  w_state_nxt = MS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= MS_EMPTY;
            r_drop  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

    // Payload registers carry no reset; the state register qualifies them.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pc       <= es_pc;
            r_result   <= es_result;
            r_dest     <= es_dest;
            r_gr_we    <= es_gr_we;
            r_load     <= es_load;
            r_mem_size <= es_mem_size;
            r_sign_ext <= es_sign_ext;
        end
        if (w_capture) begin
            r_ld_data <= w_ld_val;
        end
    end

    load_align #(
        .DATA_W (DATA_W)
    ) u_load_align (
        .i_rdata    (data_rdata),
        .i_offset   (r_result[OFF_W-1:0]),
        .i_mem_size (r_mem_size),
        .i_sign_ext (r_sign_ext),
        .o_value    (w_ld_val)
    );

    assign ms_to_ws_valid = (r_state == MS_EXEC);
    assign ws_pc          = r_pc;
    assign ws_result      = r_load ? r_ld_data : r_result;
    assign ws_dest        = r_dest;
    assign ws_gr_we       = r_gr_we;
    assign fwd_valid      = (r_state != MS_EMPTY) & r_gr_we & (r_dest != 5'd0);
    assign fwd_stall      = (r_state == MS_WAIT);
    assign fwd_dest       = r_dest;
    assign fwd_result     = ws_result;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed bench for mem_stage_pipe: a vector table of single instructions plus
// hand-written stall, flush/drop and reset sequences; 32- and 64-bit instances run in lockstep.
module tb_mem_stage_pipe;
    import mycpu_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        es_to_ms_valid;
    logic [31:0] es_pc;
    logic [31:0] es_result;
    logic [63:0] es_result64;
    logic [4:0]  es_dest;
    logic        es_gr_we;
    logic        es_load;
    logic        es_req_sent;
    logic [1:0]  es_mem_size;
    logic        es_sign_ext;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic [63:0] data_rdata64;
    logic        flush;
    logic        ws_allowin;

    logic        ms_allowin, ms_to_ws_valid, ws_gr_we, fwd_valid, fwd_stall;
    logic [31:0] ws_pc, ws_result, fwd_result;
    logic [4:0]  ws_dest, fwd_dest;

    logic        ms_allowin64, ms_to_ws_valid64, ws_gr_we64, fwd_valid64, fwd_stall64;
    logic [31:0] ws_pc64;
    logic [63:0] ws_result64, fwd_result64;
    logic [4:0]  ws_dest64, fwd_dest64;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage_pipe #(.DATA_W(32), .DROP_W(2)) dut32 (
        .clk(clk), .resetn(resetn), .es_to_ms_valid(es_to_ms_valid), .es_pc(es_pc),
        .es_result(es_result), .es_dest(es_dest), .es_gr_we(es_gr_we), .es_load(es_load),
        .es_req_sent(es_req_sent), .es_mem_size(es_mem_size), .es_sign_ext(es_sign_ext),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata), .flush(flush),
        .ws_allowin(ws_allowin), .ms_allowin(ms_allowin), .ms_to_ws_valid(ms_to_ws_valid),
        .ws_pc(ws_pc), .ws_result(ws_result), .ws_dest(ws_dest), .ws_gr_we(ws_gr_we),
        .fwd_valid(fwd_valid), .fwd_stall(fwd_stall), .fwd_dest(fwd_dest),
        .fwd_result(fwd_result)
    );

    mem_stage_pipe #(.DATA_W(64), .DROP_W(2)) dut64 (
        .clk(clk), .resetn(resetn), .es_to_ms_valid(es_to_ms_valid), .es_pc(es_pc),
        .es_result(es_result64), .es_dest(es_dest), .es_gr_we(es_gr_we), .es_load(es_load),
        .es_req_sent(es_req_sent), .es_mem_size(es_mem_size), .es_sign_ext(es_sign_ext),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata64), .flush(flush),
        .ws_allowin(ws_allowin), .ms_allowin(ms_allowin64), .ms_to_ws_valid(ms_to_ws_valid64),
        .ws_pc(ws_pc64), .ws_result(ws_result64), .ws_dest(ws_dest64), .ws_gr_we(ws_gr_we64),
        .fwd_valid(fwd_valid64), .fwd_stall(fwd_stall64), .fwd_dest(fwd_dest64),
        .fwd_result(fwd_result64)
    );

    typedef struct {
        logic        ld;
        logic [1:0]  sz;
        logic        sx;
        logic [31:0] addr;
        logic [4:0]  dest;
        logic [63:0] rdata;
        logic [63:0] exp;
        logic        w64;
        int          lat;
        logic        fv;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one cycle; also flag the drop counter ever reaching saturation.
    task automatic step();
        @(posedge clk);
        #1;
        if (resetn && (dut32.r_drop == 2'b11 || dut64.r_drop == 2'b11)) begin
            n_err++;
            $display("FAIL drop_saturated: got %0d expected below 3", dut32.r_drop);
        end
    endtask

    task automatic drive_instr(input logic ld, input logic [1:0] sz, input logic sx,
                               input logic [31:0] addr, input logic [4:0] dest);
        es_to_ms_valid = 1'b1;
        es_pc          = 32'h1C00_0000 + addr;
        es_result      = addr;
        es_result64    = 64'(addr);
        es_dest        = dest;
        es_gr_we       = 1'b1;
        es_load        = ld;
        es_req_sent    = ld;
        es_mem_size    = sz;
        es_sign_ext    = sx;
    endtask

    task automatic pulse_data(input logic [63:0] rd);
        data_data_ok = 1'b1;
        data_rdata   = rd[31:0];
        data_rdata64 = rd;
        step();
        data_data_ok = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [31:0] exp_pc;
        exp_pc     = 32'h1C00_0000 + v.addr;
        ws_allowin = 1'b1;
        drive_instr(v.ld, v.sz, v.sx, v.addr, v.dest);
        chk($sformatf("v%0d_allowin", idx), 64'(ms_allowin), 64'(1));
        step();
        es_to_ms_valid = 1'b0;
        if (v.ld) begin
            for (int i = 0; i < v.lat; i++) begin
                chk($sformatf("v%0d_stall%0d", idx, i), 64'(fwd_stall), 64'(1));
                chk($sformatf("v%0d_nvalid%0d", idx, i), 64'(ms_to_ws_valid), 64'(0));
                if (i == v.lat - 1) begin
                    data_data_ok = 1'b1;
                    data_rdata   = v.rdata[31:0];
                    data_rdata64 = v.rdata;
                end
                step();
            end
            data_data_ok = 1'b0;
        end
        if (v.w64) begin
            chk($sformatf("v%0d_valid64", idx), 64'(ms_to_ws_valid64), 64'(1));
            chk($sformatf("v%0d_result64", idx), ws_result64, v.exp);
            chk($sformatf("v%0d_fwd64", idx), fwd_result64, v.exp);
            chk($sformatf("v%0d_stall64", idx), 64'(fwd_stall64), 64'(0));
        end else begin
            chk($sformatf("v%0d_valid", idx), 64'(ms_to_ws_valid), 64'(1));
            chk($sformatf("v%0d_result", idx), 64'(ws_result), v.exp);
            chk($sformatf("v%0d_fwd_result", idx), 64'(fwd_result), v.exp);
            chk($sformatf("v%0d_stall", idx), 64'(fwd_stall), 64'(0));
            chk($sformatf("v%0d_fwd_valid", idx), 64'(fwd_valid), 64'(v.fv));
            chk($sformatf("v%0d_pc", idx), 64'(ws_pc), 64'(exp_pc));
            chk($sformatf("v%0d_dest", idx), 64'(ws_dest), 64'(v.dest));
        end
        step();
        chk($sformatf("v%0d_drained", idx), 64'(ms_to_ws_valid), 64'(0));
    endtask

    initial begin
        //           ld    sz     sx    addr           dest   rdata                   exp                     w64   lat fv
        vecs[0]  = '{1'b0, 2'b00, 1'b0, 32'h1234_5678, 5'd5,  64'h0,                  64'h1234_5678,          1'b0, 0, 1'b1};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'hA5A5_0001, 5'd0,  64'h0,                  64'hA5A5_0001,          1'b0, 0, 1'b0};
        vecs[2]  = '{1'b1, 2'b01, 1'b1, 32'h0000_1003, 5'd7,  64'h80FF_FF00,          64'hFFFF_FF80,          1'b0, 3, 1'b1};
        vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h0000_1003, 5'd7,  64'h80FF_FF00,          64'h0000_0080,          1'b0, 1, 1'b1};
        vecs[4]  = '{1'b1, 2'b01, 1'b1, 32'h0000_1001, 5'd8,  64'h80FF_FF00,          64'hFFFF_FFFF,          1'b0, 2, 1'b1};
        vecs[5]  = '{1'b1, 2'b01, 1'b1, 32'h0000_1000, 5'd8,  64'h80FF_FF00,          64'h0000_0000,          1'b0, 1, 1'b1};
        vecs[6]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0002, 5'd9,  64'hBEEF_1234,          64'h0000_BEEF,          1'b0, 2, 1'b1};
        vecs[7]  = '{1'b1, 2'b10, 1'b1, 32'h0000_0000, 5'd9,  64'h1234_8001,          64'hFFFF_8001,          1'b0, 1, 1'b1};
        vecs[8]  = '{1'b1, 2'b10, 1'b1, 32'h0000_0002, 5'd9,  64'h7FFF_0000,          64'h0000_7FFF,          1'b0, 1, 1'b1};
        vecs[9]  = '{1'b1, 2'b00, 1'b1, 32'h0000_0004, 5'd10, 64'hDEAD_BEEF,          64'hDEAD_BEEF,          1'b0, 2, 1'b1};
        vecs[10] = '{1'b1, 2'b10, 1'b0, 32'h0000_0003, 5'd11, 64'hBEEF_1234,          64'h0000_BEEF,          1'b0, 1, 1'b1};
        vecs[11] = '{1'b1, 2'b00, 1'b0, 32'h0000_0006, 5'd11, 64'hCAFE_BABE,          64'hCAFE_BABE,          1'b0, 1, 1'b1};
        vecs[12] = '{1'b1, 2'b11, 1'b0, 32'h0000_0008, 5'd12, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b1, 2, 1'b1};
        vecs[13] = '{1'b1, 2'b00, 1'b1, 32'h0000_0004, 5'd12, 64'hCAFE_F00D_1111_1111, 64'hFFFF_FFFF_CAFE_F00D, 1'b1, 1, 1'b1};
        vecs[14] = '{1'b1, 2'b01, 1'b1, 32'h0000_0007, 5'd13, 64'hF000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFF0, 1'b1, 1, 1'b1};
        vecs[15] = '{1'b1, 2'b01, 1'b0, 32'h0000_0001, 5'd0,  64'h0000_AB00,          64'h0000_00AB,          1'b0, 1, 1'b0};

        resetn = 1'b0;
        es_to_ms_valid = 1'b0; es_pc = '0; es_result = '0; es_result64 = '0; es_dest = '0;
        es_gr_we = 1'b0; es_load = 1'b0; es_req_sent = 1'b0; es_mem_size = '0;
        es_sign_ext = 1'b0; data_data_ok = 1'b0; data_rdata = '0; data_rdata64 = '0;
        flush = 1'b0; ws_allowin = 1'b1;

        #3;
        chk("rst_valid", 64'(ms_to_ws_valid), 64'(0));
        chk("rst_fwd_valid", 64'(fwd_valid), 64'(0));
        chk("rst_fwd_stall", 64'(fwd_stall), 64'(0));
        chk("rst_allowin", 64'(ms_allowin), 64'(1));
        step();
        step();
        resetn = 1'b1;
        step();

        for (int i = 0; i < 16; i++) begin
            run_vec(i, vecs[i]);
        end

        // Response arriving in EMPTY is ignored.
        pulse_data(64'hFFFF_FFFF);
        chk("empty_ok_valid", 64'(ms_to_ws_valid), 64'(0));
        chk("empty_ok_stall", 64'(fwd_stall), 64'(0));
        chk("empty_ok_allowin", 64'(ms_allowin), 64'(1));

        // Load result held while WB is stalled; a stray response in EXEC changes nothing.
        ws_allowin = 1'b0;
        drive_instr(1'b1, MEM_SIZE_W, 1'b0, 32'h0000_0004, 5'd3);
        step();
        es_to_ms_valid = 1'b0;
        pulse_data(64'h1122_3344);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("hold%0d_valid", k), 64'(ms_to_ws_valid), 64'(1));
            chk($sformatf("hold%0d_result", k), 64'(ws_result), 64'h1122_3344);
            chk($sformatf("hold%0d_allowin", k), 64'(ms_allowin), 64'(0));
            if (k == 1) begin
                pulse_data(64'hFFFF_FFFF);
            end else begin
                step();
            end
        end
        ws_allowin = 1'b1;
        #1;
        chk("hold_release_allowin", 64'(ms_allowin), 64'(1));
        step();
        chk("hold_release_empty", 64'(ms_to_ws_valid), 64'(0));

        // Flush in WAIT: stale response dropped, next load stalls, then gets its own data.
        drive_instr(1'b1, MEM_SIZE_B, 1'b1, 32'h0000_0000, 5'd4);
        step();
        es_to_ms_valid = 1'b0;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fw_drop1", 64'(dut32.r_drop), 64'(1));
        chk("fw_stall", 64'(fwd_stall), 64'(0));
        chk("fw_allowin", 64'(ms_allowin), 64'(0));
        drive_instr(1'b1, MEM_SIZE_H, 1'b0, 32'h0000_0002, 5'd6);
        step();
        chk("fw_blocked_stall", 64'(fwd_stall), 64'(0));
        pulse_data(64'hFFFF_FFFF);
        chk("fw_drop0", 64'(dut32.r_drop), 64'(0));
        chk("fw_not_captured", 64'(ms_to_ws_valid), 64'(0));
        chk("fw_allowin_back", 64'(ms_allowin), 64'(1));
        step();
        es_to_ms_valid = 1'b0;
        chk("fw_new_waits", 64'(fwd_stall), 64'(1));
        step();
        chk("fw_still_waits", 64'(fwd_stall), 64'(1));
        pulse_data(64'hBEEF_1234);
        chk("fw_new_valid", 64'(ms_to_ws_valid), 64'(1));
        chk("fw_new_result", 64'(ws_result), 64'h0000_BEEF);
        step();

        // Flush in WAIT plus a flushed EX load with its request out: two responses dropped.
        drive_instr(1'b1, MEM_SIZE_W, 1'b0, 32'h0000_0000, 5'd4);
        step();
        drive_instr(1'b1, MEM_SIZE_W, 1'b0, 32'h0000_0004, 5'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        es_to_ms_valid = 1'b0;
        chk("dd_drop2", 64'(dut32.r_drop), 64'(2));
        chk("dd_allowin", 64'(ms_allowin), 64'(0));
        pulse_data(64'h1111_1111);
        chk("dd_drop1", 64'(dut32.r_drop), 64'(1));
        chk("dd_valid", 64'(ms_to_ws_valid), 64'(0));
        pulse_data(64'h2222_2222);
        chk("dd_drop0", 64'(dut32.r_drop), 64'(0));
        chk("dd_allowin_back", 64'(ms_allowin), 64'(1));

        // Flush coinciding with the response in WAIT owes nothing.
        drive_instr(1'b1, MEM_SIZE_W, 1'b0, 32'h0000_0000, 5'd4);
        step();
        es_to_ms_valid = 1'b0;
        flush = 1'b1;
        pulse_data(64'h3333_3333);
        flush = 1'b0;
        chk("fo_drop0", 64'(dut32.r_drop), 64'(0));
        chk("fo_valid", 64'(ms_to_ws_valid), 64'(0));
        chk("fo_allowin", 64'(ms_allowin), 64'(1));

        // Flush blocks an accept in the same cycle, and kills an EXEC entry.
        drive_instr(1'b0, MEM_SIZE_W, 1'b0, 32'h0000_0040, 5'd2);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fb_not_accepted", 64'(ms_to_ws_valid), 64'(0));
        ws_allowin = 1'b0;
        step();
        es_to_ms_valid = 1'b0;
        chk("fx_valid", 64'(ms_to_ws_valid), 64'(1));
        chk("fx_fwd_valid", 64'(fwd_valid), 64'(1));
        flush = 1'b1;
        step();
        flush = 1'b0;
        ws_allowin = 1'b1;
        chk("fx_killed", 64'(ms_to_ws_valid), 64'(0));
        chk("fx_fwd_killed", 64'(fwd_valid), 64'(0));

        // Asynchronous reset in WAIT discards the pending load.
        drive_instr(1'b1, MEM_SIZE_W, 1'b0, 32'h0000_0000, 5'd4);
        step();
        es_to_ms_valid = 1'b0;
        chk("rw_stall", 64'(fwd_stall), 64'(1));
        resetn = 1'b0;
        #1;
        chk("rw_async_stall", 64'(fwd_stall), 64'(0));
        chk("rw_async_fwd", 64'(fwd_valid), 64'(0));
        step();
        resetn = 1'b1;
        step();
        chk("rw_valid", 64'(ms_to_ws_valid), 64'(0));
        chk("rw_allowin", 64'(ms_allowin), 64'(1));
        chk("rw_drop", 64'(dut32.r_drop), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
